mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 Op  input  6  instruction opcode IR[31:26], held stable by the instruction register from the end of FETCH.
REQ-004 Funct  input  6  function field IR[5:0], same stability as Op.
REQ-005 Zero  input  1  ALU equality flag, high when ALU operands are equal.
REQ-006 PCWr  output  1  PC write enable.
REQ-007 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 MemRd  output  1  memory read strobe.
REQ-009 MemWr  output  1  memory write strobe.
REQ-010 IRWr  output  1  instruction register write enable.
REQ-011 RegWr  output  1  register file write enable.
REQ-012 RegDst  output  2  write register select: 00 = rt, 01 = rd, 10 = $31.
REQ-013 MemtoReg  output  2  write data select: 00 = ALUOut, 01 = MDR, 10 = PC.
REQ-014 ExtOp  output  1  immediate extension: 1 = sign, 0 = zero.
REQ-015 ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-016 ALUSrcB  output  2  ALU B select: 00 = register B, 01 = 4, 10 = ext(imm), 11 = sext(imm)<<2.
REQ-017 ALUOp  output  5  operation code: NOP=0 ADDU=1 ADD=2 SUBU=3 SUB=4 AND=5 OR=6 NOR=7 XOR=8 SLT=9 SLTU=10 SLL=11 SRL=12 SRA=13.
REQ-018 PCSource  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-019 State  output  4  current state encoding, used for debug and verification.

Function
REQ-020 The FSM SHALL have the states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXE=6, RWB=7, IEXE=8, IWB=9, BRANCH=10, JUMP=11; codes 12-15 SHALL return to FETCH.
REQ-021 All outputs SHALL be Moore-decoded from State, Op and Funct; any output not listed for a state SHALL be 0.
REQ-022 FETCH: MemRd=1, IRWr=1, ALUSrcB=01, ALUOp=ADDU, PCWr=1; next state is DECODE.
REQ-023 DECODE: ALUSrcB=11, ALUOp=ADDU (precomputes the branch target).
- Next state by opcode: lw/sw -> MEMADR; R-type (000000) -> REXE; addi/addiu/slti/sltiu/andi/ori/xori -> IEXE; beq/bne -> BRANCH; j/jal -> JUMP.
- Unsupported opcode, or R-type with unsupported Funct -> FETCH.
REQ-024 MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=ADDU; lw (100011) -> MEMRD, sw (101011) -> MEMWR.
REQ-025 MEMRD: IorD=1, MemRd=1 -> MEMWB; MEMWB: RegWr=1, RegDst=00, MemtoReg=01 -> FETCH.
REQ-026 MEMWR: IorD=1, MemWr=1 -> FETCH.
REQ-027 REXE: ALUSrcA=1, ALUSrcB=00, ALUOp mapped from Funct -> RWB.
- addu 100001->ADDU, add 100000->ADD, subu 100011->SUBU, sub 100010->SUB.
- and 100100->AND, or 100101->OR, xor 100110->XOR, nor 100111->NOR.
- slt 101010->SLT, sltu 101011->SLTU.
- sllv 000100->SLL, srlv 000110->SRL, srav 000111->SRA.
REQ-028 RWB: RegWr=1, RegDst=01, MemtoReg=00 -> FETCH.
REQ-029 IEXE: ALUSrcA=1, ALUSrcB=10 -> IWB.
- addi: ADD, addiu: ADDU, slti: SLT, sltiu: SLTU, each with ExtOp=1.
- andi: AND, ori: OR, xori: XOR, each with ExtOp=0.
REQ-030 IWB: RegWr=1, RegDst=00, MemtoReg=00 -> FETCH.
REQ-031 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUBU, PCSource=01 -> FETCH.
- PCWr = Zero for beq (000100); PCWr = ~Zero for bne (000101).
REQ-032 JUMP: PCSource=10, PCWr=1 -> FETCH.
- jal (000011) additionally drives RegWr=1, RegDst=10, MemtoReg=10.
REQ-033 Instruction latency SHALL be: lw 5 cycles; sw, R-type and I-type ALU 4 cycles; beq/bne/j/jal 3 cycles; unsupported 2 cycles.

Reset
REQ-034 While rst=1, State SHALL be FETCH immediately without waiting for a clock edge, and outputs SHALL be the FETCH values; reset asserted mid-instruction SHALL abandon that instruction, and the first rising edge after release SHALL advance to DECODE.

Verification
REQ-035 Reset asserted in MEMRD mid-lw -> State=0 without a clock edge; after release, State sequence 0,1 with IRWr=1 only in state 0.
REQ-036 Op=100011 -> State 0,1,2,3,4,0; MemRd=1 in states 3/0, RegWr=1 and MemtoReg=01 only in state 4.
REQ-037 Op=000000, Funct=101010 -> ALUOp=9 in state 6; RegWr=1 and RegDst=01 in state 7.
REQ-038 Op=000101 with Zero=1 -> PCWr=0 in state 10; with Zero=0 -> PCWr=1 and PCSource=01.
REQ-039 Op=000011 -> state 11 with PCWr=1, RegDst=10, MemtoReg=10; Op=111111 -> State 0,1,0 with no write strobes after FETCH.
REQ-040 Op=001101 -> ALUOp=6 and ExtOp=0 in state 8; Op=001000 -> ALUOp=2 and ExtOp=1.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-style control unit.
// Twelve-state Moore FSM. Outputs are decoded from the current state plus
// the latched Op/Funct fields (and Zero for conditional branches).
module mc_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       PCWr,
   output logic       IorD,
   output logic       MemRd,
   output logic       MemWr,
   output logic       IRWr,
   output logic       RegWr,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       ExtOp,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [4:0] ALUOp,
   output logic [1:0] PCSource,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXE   = 4'd6,  S_RWB   = 4'd7,
      S_IEXE   = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP  = 4'd11
   } state_t;

   // opcodes
   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // ALU operation codes
   localparam logic [4:0] A_NOP  = 5'd0;
   localparam logic [4:0] A_ADDU = 5'd1;
   localparam logic [4:0] A_ADD  = 5'd2;
   localparam logic [4:0] A_SUBU = 5'd3;
   localparam logic [4:0] A_SUB  = 5'd4;
   localparam logic [4:0] A_AND  = 5'd5;
   localparam logic [4:0] A_OR   = 5'd6;
   localparam logic [4:0] A_NOR  = 5'd7;
   localparam logic [4:0] A_XOR  = 5'd8;
   localparam logic [4:0] A_SLT  = 5'd9;
   localparam logic [4:0] A_SLTU = 5'd10;
   localparam logic [4:0] A_SLL  = 5'd11;
   localparam logic [4:0] A_SRL  = 5'd12;
   localparam logic [4:0] A_SRA  = 5'd13;

   state_t     state, state_nx;
   logic [4:0] r_alu, i_alu;
   logic       r_ok, i_ok, i_ext;

   // R-type Funct -> ALU operation; r_ok flags a supported Funct
   always_comb begin
      r_alu = A_NOP;
      r_ok  = 1'b1;
      case (Funct)
         6'b100001: r_alu = A_ADDU;
         6'b100000: r_alu = A_ADD;
         6'b100011: r_alu = A_SUBU;
         6'b100010: r_alu = A_SUB;
         6'b100100: r_alu = A_AND;
         6'b100101: r_alu = A_OR;
         6'b100110: r_alu = A_XOR;
         6'b100111: r_alu = A_NOR;
         6'b101010: r_alu = A_SLT;
         6'b101011: r_alu = A_SLTU;
         6'b000100: r_alu = A_SLL;
         6'b000110: r_alu = A_SRL;
         6'b000111: r_alu = A_SRA;
         default:   r_ok  = 1'b0;
      endcase
   end

   // I-type ALU opcode -> ALU operation and immediate extension mode
   always_comb begin
      i_alu = A_NOP;
      i_ext = 1'b0;
      i_ok  = 1'b1;
      case (Op)
         OP_ADDI:  begin i_alu = A_ADD;  i_ext = 1'b1; end
         OP_ADDIU: begin i_alu = A_ADDU; i_ext = 1'b1; end
         OP_SLTI:  begin i_alu = A_SLT;  i_ext = 1'b1; end
         OP_SLTIU: begin i_alu = A_SLTU; i_ext = 1'b1; end
         OP_ANDI:  i_alu = A_AND;
         OP_ORI:   i_alu = A_OR;
         OP_XORI:  i_alu = A_XOR;
         default:  i_ok  = 1'b0;
      endcase
   end

   // state register; reset forces FETCH asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FETCH;
      else     state <= state_nx;
   end

   // next state and Moore outputs; anything not driven below stays 0
   always_comb begin
      state_nx = S_FETCH;
      PCWr     = 1'b0;
      IorD     = 1'b0;
      MemRd    = 1'b0;
      MemWr    = 1'b0;
      IRWr     = 1'b0;
      RegWr    = 1'b0;
      RegDst   = 2'b00;
      MemtoReg = 2'b00;
      ExtOp    = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = A_NOP;
      PCSource = 2'b00;
      case (state)
         S_FETCH: begin
            MemRd = 1'b1; IRWr = 1'b1; PCWr = 1'b1;
            ALUSrcB = 2'b01; ALUOp = A_ADDU;
            state_nx = S_DECODE;
         end
         S_DECODE: begin
            // branch target computed speculatively while decoding
            ALUSrcB = 2'b11; ALUOp = A_ADDU;
            if (Op == OP_LW || Op == OP_SW)        state_nx = S_MEMADR;
            else if (Op == OP_R)                   state_nx = r_ok ? S_REXE : S_FETCH;
            else if (i_ok)                         state_nx = S_IEXE;
            else if (Op == OP_BEQ || Op == OP_BNE) state_nx = S_BRANCH;
            else if (Op == OP_J || Op == OP_JAL)   state_nx = S_JUMP;
            else                                   state_nx = S_FETCH;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1; ALUSrcB = 2'b10; ExtOp = 1'b1; ALUOp = A_ADDU;
            state_nx = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            IorD = 1'b1; MemRd = 1'b1;
            state_nx = S_MEMWB;
         end
         S_MEMWB: begin
            RegWr = 1'b1; RegDst = 2'b00; MemtoReg = 2'b01;
         end
         S_MEMWR: begin
            IorD = 1'b1; MemWr = 1'b1;
         end
         S_REXE: begin
            ALUSrcA = 1'b1; ALUSrcB = 2'b00; ALUOp = r_alu;
            state_nx = S_RWB;
         end
         S_RWB: begin
            RegWr = 1'b1; RegDst = 2'b01; MemtoReg = 2'b00;
         end
         S_IEXE: begin
            ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUOp = i_alu; ExtOp = i_ext;
            state_nx = S_IWB;
         end
         S_IWB: begin
            RegWr = 1'b1; RegDst = 2'b00; MemtoReg = 2'b00;
         end
         S_BRANCH: begin
            ALUSrcA = 1'b1; ALUSrcB = 2'b00; ALUOp = A_SUBU; PCSource = 2'b01;
            PCWr = (Op == OP_BNE) ? ~Zero : Zero;
         end
         S_JUMP: begin
            PCSource = 2'b10; PCWr = 1'b1;
            if (Op == OP_JAL) begin
               RegWr = 1'b1; RegDst = 2'b10; MemtoReg = 2'b10;
            end
         end
         default: state_nx = S_FETCH;
      endcase
   end

   assign State = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed bench for mc_ctrl. An instruction-level model derives
// the expected state walk and per-state control word; a negedge process
// compares the DUT against it, and literal checks pin key values.
module tb_mc_ctrl;

   typedef struct packed {
      logic       pcwr, iord, memrd, memwr, irwr, regwr;
      logic [1:0] regdst, memtoreg;
      logic       extop, alusrca;
      logic [1:0] alusrcb;
      logic [4:0] aluop;
      logic [1:0] pcsource;
   } ctl_t;

   typedef enum logic [3:0] {C_LW, C_SW, C_R, C_I, C_BEQ, C_BNE, C_J, C_JAL, C_BAD} cls_t;
   typedef struct packed {
      cls_t       cls;
      logic [4:0] alu;
      logic       ext;
   } info_t;
   typedef int q_t[$];

   logic       clk = 1'b0, rst = 1'b0, zero = 1'b0;
   logic [5:0] op = '0, fn = '0;
   logic       pcwr, iord, memrd, memwr, irwr, regwr, extop, alusrca;
   logic [1:0] regdst, memtoreg, alusrcb, pcsource;
   logic [4:0] aluop;
   logic [3:0] state;
   ctl_t       dut_ctl;

   int         checks = 0, errors = 0;
   logic       chk_en = 1'b0;
   logic [3:0] exp_st = '0;
   ctl_t       exp_c = '0;
   string      tag = "";
   ctl_t       cap[16];
   int         lat;

   always #5 clk = ~clk;

   mc_ctrl dut (
      .clk(clk), .rst(rst), .Op(op), .Funct(fn), .Zero(zero),
      .PCWr(pcwr), .IorD(iord), .MemRd(memrd), .MemWr(memwr), .IRWr(irwr),
      .RegWr(regwr), .RegDst(regdst), .MemtoReg(memtoreg), .ExtOp(extop),
      .ALUSrcA(alusrca), .ALUSrcB(alusrcb), .ALUOp(aluop), .PCSource(pcsource),
      .State(state)
   );

   assign dut_ctl = {pcwr, iord, memrd, memwr, irwr, regwr, regdst, memtoreg,
                     extop, alusrca, alusrcb, aluop, pcsource};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // what an instruction is, from its opcode/funct
   function automatic info_t decode(input logic [5:0] o, input logic [5:0] f);
      info_t r;
      r = '{cls: C_BAD, alu: 5'd0, ext: 1'b0};
      case (o)
         6'b100011: r.cls = C_LW;
         6'b101011: r.cls = C_SW;
         6'b000100: r.cls = C_BEQ;
         6'b000101: r.cls = C_BNE;
         6'b000010: r.cls = C_J;
         6'b000011: r.cls = C_JAL;
         6'b001000: r = '{cls: C_I, alu: 5'd2,  ext: 1'b1};
         6'b001001: r = '{cls: C_I, alu: 5'd1,  ext: 1'b1};
         6'b001010: r = '{cls: C_I, alu: 5'd9,  ext: 1'b1};
         6'b001011: r = '{cls: C_I, alu: 5'd10, ext: 1'b1};
         6'b001100: r = '{cls: C_I, alu: 5'd5,  ext: 1'b0};
         6'b001101: r = '{cls: C_I, alu: 5'd6,  ext: 1'b0};
         6'b001110: r = '{cls: C_I, alu: 5'd8,  ext: 1'b0};
         6'b000000: begin
            r.cls = C_R;
            case (f)
               6'b100001: r.alu = 5'd1;   6'b100000: r.alu = 5'd2;
               6'b100011: r.alu = 5'd3;   6'b100010: r.alu = 5'd4;
               6'b100100: r.alu = 5'd5;   6'b100101: r.alu = 5'd6;
               6'b100110: r.alu = 5'd8;   6'b100111: r.alu = 5'd7;
               6'b101010: r.alu = 5'd9;   6'b101011: r.alu = 5'd10;
               6'b000100: r.alu = 5'd11;  6'b000110: r.alu = 5'd12;
               6'b000111: r.alu = 5'd13;
               default:   r.cls = C_BAD;
            endcase
         end
         default: r.cls = C_BAD;
      endcase
      return r;
   endfunction

   // the state walk of one instruction, starting at FETCH
   function automatic q_t walk(input info_t inf);
      q_t p;
      p = '{0, 1};
      case (inf.cls)
         C_LW:         p = {p, 2, 3, 4};
         C_SW:         p = {p, 2, 5};
         C_R:          p = {p, 6, 7};
         C_I:          p = {p, 8, 9};
         C_BEQ, C_BNE: p = {p, 10};
         C_J, C_JAL:   p = {p, 11};
         default:      ;
      endcase
      return p;
   endfunction

   // control word for a step of the instruction
   function automatic ctl_t model(input int st, input info_t inf, input logic z);
      ctl_t c;
      c = '0;
      case (st)
         0:  begin c.pcwr = 1; c.memrd = 1; c.irwr = 1; c.alusrcb = 2'd1; c.aluop = 5'd1; end
         1:  begin c.alusrcb = 2'd3; c.aluop = 5'd1; end
         2:  begin c.alusrca = 1; c.alusrcb = 2'd2; c.extop = 1; c.aluop = 5'd1; end
         3:  begin c.iord = 1; c.memrd = 1; end
         4:  begin c.regwr = 1; c.memtoreg = 2'd1; end
         5:  begin c.iord = 1; c.memwr = 1; end
         6:  begin c.alusrca = 1; c.aluop = inf.alu; end
         7:  begin c.regwr = 1; c.regdst = 2'd1; end
         8:  begin c.alusrca = 1; c.alusrcb = 2'd2; c.aluop = inf.alu; c.extop = inf.ext; end
         9:  c.regwr = 1;
         10: begin
            c.alusrca = 1; c.aluop = 5'd3; c.pcsource = 2'd1;
            c.pcwr = (inf.cls == C_BNE) ? ~z : z;
         end
         11: begin
            c.pcsource = 2'd2; c.pcwr = 1;
            if (inf.cls == C_JAL) begin c.regwr = 1; c.regdst = 2'd2; c.memtoreg = 2'd2; end
         end
         default: ;
      endcase
      return c;
   endfunction

   // compare DUT to the model on every checked cycle
   always @(negedge clk) begin
      if (chk_en) begin
         chk({tag, "/state"}, 32'(state), 32'(exp_st));
         chk({tag, "/ctl"}, 32'(dut_ctl), 32'(exp_c));
      end
   end

   // run one instruction from FETCH; stop_at truncates the walk
   task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z,
                      input string nm, input int stop_at = 99);
      info_t inf;
      q_t    p;
      op = o; fn = f; zero = z; tag = nm;
      inf = decode(o, f);
      p = walk(inf);
      lat = 0;
      for (int k = 0; k < p.size() && k < stop_at; k++) begin
         exp_st = 4'(p[k]);
         exp_c  = model(p[k], inf, z);
         chk_en = 1'b1;
         @(negedge clk); #1;
         cap[state] = dut_ctl;
         if (k == 0 || state != 4'd0) lat++;
         @(posedge clk); #1;
      end
      chk_en = 1'b0;
   endtask

   typedef struct packed { logic [5:0] o, f; logic z; } vec_t;
   vec_t vecs[19];

   initial begin
      vecs = '{
         '{6'b101011, 6'h00, 1'b0}, '{6'b000000, 6'b100001, 1'b0}, '{6'b000000, 6'b100000, 1'b0},
         '{6'b000000, 6'b100011, 1'b0}, '{6'b000000, 6'b100010, 1'b0}, '{6'b000000, 6'b100100, 1'b0},
         '{6'b000000, 6'b100101, 1'b0}, '{6'b000000, 6'b100110, 1'b0}, '{6'b000000, 6'b100111, 1'b0},
         '{6'b000000, 6'b101011, 1'b0}, '{6'b000000, 6'b000100, 1'b0}, '{6'b000000, 6'b000110, 1'b0},
         '{6'b000000, 6'b000111, 1'b0}, '{6'b001001, 6'h00, 1'b0}, '{6'b001010, 6'h00, 1'b0},
         '{6'b001011, 6'h00, 1'b0}, '{6'b001100, 6'h00, 1'b0}, '{6'b001110, 6'h00, 1'b0},
         '{6'b000010, 6'h00, 1'b0}};

      // asynchronous reset before any clock edge
      #1 rst = 1'b1;
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_pcwr", 32'(pcwr), 32'd1);
      chk("rst_irwr", 32'(irwr), 32'd1);
      chk("rst_ctl", 32'(dut_ctl), 32'(model(0, decode(6'b111111, 6'h0), 1'b0)));
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;

      // lw
      run(6'b100011, 6'h00, 1'b0, "lw");
      chk("lw_lat", 32'(lat), 32'd5);
      chk("lw_memrd3", 32'(cap[3].memrd), 32'd1);
      chk("lw_memrd0", 32'(cap[0].memrd), 32'd1);
      chk("lw_regwr4", 32'(cap[4].regwr), 32'd1);
      chk("lw_m2r4", 32'(cap[4].memtoreg), 32'd1);
      chk("lw_regwr3", 32'(cap[3].regwr), 32'd0);

      // slt
      run(6'b000000, 6'b101010, 1'b0, "slt");
      chk("slt_lat", 32'(lat), 32'd4);
      chk("slt_aluop", 32'(cap[6].aluop), 32'd9);
      chk("slt_regwr", 32'(cap[7].regwr), 32'd1);
      chk("slt_regdst", 32'(cap[7].regdst), 32'd1);

      // branches
      run(6'b000101, 6'h00, 1'b1, "bne_z1");
      chk("bne_z1_pcwr", 32'(cap[10].pcwr), 32'd0);
      run(6'b000101, 6'h00, 1'b0, "bne_z0");
      chk("bne_z0_pcwr", 32'(cap[10].pcwr), 32'd1);
      chk("bne_z0_pcsrc", 32'(cap[10].pcsource), 32'd1);
      chk("bne_lat", 32'(lat), 32'd3);
      run(6'b000100, 6'h00, 1'b1, "beq_z1");
      chk("beq_z1_pcwr", 32'(cap[10].pcwr), 32'd1);
      run(6'b000100, 6'h00, 1'b0, "beq_z0");
      chk("beq_z0_pcwr", 32'(cap[10].pcwr), 32'd0);

      // jal
      run(6'b000011, 6'h00, 1'b0, "jal");
      chk("jal_pcwr", 32'(cap[11].pcwr), 32'd1);
      chk("jal_regdst", 32'(cap[11].regdst), 32'd2);
      chk("jal_m2r", 32'(cap[11].memtoreg), 32'd2);

      // unsupported opcode and unsupported R-type funct
      run(6'b111111, 6'h00, 1'b0, "badop");
      chk("badop_lat", 32'(lat), 32'd2);
      chk("badop_strobes", 32'({cap[1].pcwr, cap[1].memwr, cap[1].regwr, cap[1].irwr}), 32'd0);
      run(6'b000000, 6'b001000, 1'b0, "badfn");
      chk("badfn_lat", 32'(lat), 32'd2);

      // I-type
      run(6'b001101, 6'h00, 1'b0, "ori");
      chk("ori_aluop", 32'(cap[8].aluop), 32'd6);
      chk("ori_ext", 32'(cap[8].extop), 32'd0);
      run(6'b001000, 6'h00, 1'b0, "addi");
      chk("addi_aluop", 32'(cap[8].aluop), 32'd2);
      chk("addi_ext", 32'(cap[8].extop), 32'd1);
      chk("addi_lat", 32'(lat), 32'd4);

      // remaining table
      foreach (vecs[i]) run(vecs[i].o, vecs[i].f, vecs[i].z, $sformatf("vec%0d", i));
      run(6'b101011, 6'h00, 1'b0, "sw_lat");
      chk("sw_lat", 32'(lat), 32'd4);

      // reset asserted mid-lw while in MEMRD
      run(6'b100011, 6'h00, 1'b0, "lw_abort", 3);
      chk("abort_pre", 32'(state), 32'd3);
      #2 rst = 1'b1;
      #1;
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_ctl", 32'(dut_ctl), 32'(model(0, decode(6'b100011, 6'h0), 1'b0)));
      @(posedge clk); #1;
      chk("abort_hold", 32'(state), 32'd0);
      rst = 1'b0;
      run(6'b100011, 6'h00, 1'b0, "lw_after");
      chk("after_irwr0", 32'(cap[0].irwr), 32'd1);
      chk("after_irwr1", 32'(cap[1].irwr), 32'd0);
      chk("after_lat", 32'(lat), 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
